// File: rtl/lutram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lutram_arb_pkg
// Description : Shared constants, FSM state type and request record for the
//               two-port LUT RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lutram_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage : lutram_arb_pkg
`default_nettype wire

// File: rtl/lutram_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : lutram_rr_arbiter2
// Description : Two-way round-robin arbiter. One-hot grant, remembers the
//               last winner so the other port takes the next tie.
// Revision    : 1.0 - initial release
// ============================================================================
module lutram_rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // Reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (|o_grant) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule : lutram_rr_arbiter2
`default_nettype wire

// File: rtl/lutram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lutram_port_arbiter
// Description : Shares a single-write-port, async-read LUT RAM between two
//               valid/ready clients with registered read responses.
//               Optional post-reset zero sweep: LUTRAM_ARB_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lutram_port_arbiter #(
    parameter int ADDR_W = lutram_arb_pkg::ADDR_W,
    parameter int DATA_W = lutram_arb_pkg::DATA_W,
    parameter int DEPTH  = lutram_arb_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,

    output logic              init_done,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    import lutram_arb_pkg::*;

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("lutram_port_arbiter: DEPTH must equal 2**ADDR_W");
    end

`ifdef LUTRAM_ARB_CLEAR_EN
    localparam state_t c_entry_state = CLEAR;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] r_clr_cnt;
`else
    localparam state_t c_entry_state = SERVE;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              w_serve;
    logic [1:0]        w_grant;
    logic              w_rd0;
    logic              w_rd1;
    req_t              w_req0;
    req_t              w_req1;
    req_t              w_sel;

    assign w_req0 = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
    assign w_req1 = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
    assign w_sel  = w_grant[1] ? w_req1 : w_req0;

    assign w_serve   = (r_state == SERVE) && !reset;
    assign init_done = w_serve;

    lutram_rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .i_en    (w_serve),
        .i_valid ({req1_valid, req0_valid}),
        .o_grant (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    assign w_rd0 = w_grant[0] & ~req0_we;
    assign w_rd1 = w_grant[1] & ~req1_we;

    // Address is parked on the last value when idle so the RAM read port
    // does not toggle needlessly.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = r_addr_hold;
        ram_din  = '0;
        if (reset) begin
            ram_addr = '0;
        end
`ifdef LUTRAM_ARB_CLEAR_EN
        else if (r_state == CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = r_clr_cnt;
            ram_din  = '0;
        end
`endif
        else if (|w_grant) begin
            ram_we   = w_sel.we;
            ram_addr = w_sel.addr;
            ram_din  = w_sel.wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr_hold <= '0;
        end else begin
            r_addr_hold <= ram_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_entry_state;
`ifdef LUTRAM_ARB_CLEAR_EN
            r_clr_cnt <= '0;
`endif
        end else begin
            case (r_state)
`ifdef LUTRAM_ARB_CLEAR_EN
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == c_last_addr) begin
                        r_state <= SERVE;
                    end
                end
`endif
                default: r_state <= SERVE;
            endcase
        end
    end

    // Async RAM read is captured at the edge closing the grant cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= w_rd0;
            rsp1_valid <= w_rd1;
            if (w_rd0) begin
                rsp0_data <= ram_dout;
            end
            if (w_rd1) begin
                rsp1_data <= ram_dout;
            end
        end
    end

endmodule : lutram_port_arbiter
`default_nettype wire

// File: doc/lutram_port_arbiter.md
Name: lutram_port_arbiter

Overview:
- Sequences and shares one 32-deep x 16-bit LUT RAM between two requesters (port 0, port 1).
- The RAM has a single write port and an asynchronous read on the same address.
- The block drives the RAM's we/addr/din and samples its dout. It sits between the RAM and two pipeline clients.
- Provides valid/ready request handshakes, round-robin arbitration, registered read responses and an optional post-reset clear sweep.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 16, RAM data width
DEPTH, 32, RAM entries (must equal 2**ADDR_W)

Ports:
clock  input  1  single clock for everything
reset  input  1  synchronous, active-high reset
req0_valid  input  1  port 0 request present
req0_ready  output  1  port 0 request accepted this cycle
req0_we  input  1  1 = write, 0 = read
req0_addr  input  ADDR_W  port 0 address
req0_wdata  input  DATA_W  port 0 write data
rsp0_valid  output  1  port 0 read data valid
rsp0_data  output  DATA_W  port 0 read data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata  (same as port 0, for port 1)
rsp1_valid, rsp1_data  (same as port 0, for port 1)
init_done  output  1  RAM ready for service
ram_we  output  1  to RAM write enable
ram_addr  output  ADDR_W  to RAM address
ram_din  output  DATA_W  to RAM write data
ram_dout  input  DATA_W  from RAM asynchronous read data

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high, sampled on the rising edge of `clock`.
- Reset values:
  - req*_ready=0, rsp*_valid=0, rsp*_data=0.
  - init_done=0, ram_we=0, ram_addr=0, ram_din=0.
  - Round-robin pointer last_grant=1, so port 0 wins the first tie.
- States:
  - CLEAR: present only with the optional feature. Walks addresses.
  - SERVE: normal operation.
- Reset entry: reset enters CLEAR if the feature is compiled in, otherwise SERVE. Asserting reset in any state, including mid-CLEAR, aborts and restarts from this entry state.
- SERVE, readiness: init_done=1. req*_ready is combinational from the arbitration:
  - only req0_valid: ready0=1.
  - only req1_valid: ready1=1.
  - both valid: grant the port != last_grant.
  - At most one ready per cycle. ready is never asserted without the matching valid.
- SERVE, RAM drive: ram_addr/ram_din/ram_we are combinational from the granted request; ram_we = granted & req_we.
  - No grant: ram_we=0 and ram_addr holds its previous value.
- SERVE, pointer update: last_grant updates only on a grant.
- Read latency:
  - Accepted read at cycle N: rspX_data <= ram_dout at the edge ending N.
  - rspX_valid=1 for exactly cycle N+1.
  - rsp_data holds its value until the next read response for that port.
- Back-to-back reads from one port give one response per cycle. No backpressure on responses.
- Writes produce no response. Write at N followed by a read of the same address at N+1 returns the new data.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1,...
- Same-address conflict: two requesters targeting the same address in one cycle is ordinary arbitration. The loser retries and sees the winner's write.

Optional Feature:
Macro LUTRAM_ARB_CLEAR_EN.
- Defined:
  - After reset, the CLEAR state writes 0 to addresses 0..DEPTH-1, one per cycle (ram_we=1, ram_din=0). This takes 32 cycles.
  - req*_ready=0 and init_done=0 throughout CLEAR.
  - After the write to DEPTH-1, move to SERVE; init_done=1 from the next cycle.
  - A 5-bit clear counter wraps to 0 on exit.
- Undefined:
  - No CLEAR state and no counter. Enter SERVE directly, with init_done=1 from the first cycle after reset deasserts.
  - RAM contents are whatever the RAM's INIT values give.

Decomposition:
- Package lutram_arb_pkg: ADDR_W/DATA_W/DEPTH constants, state enum {CLEAR, SERVE}, and a request struct {we, addr, wdata}.
- One natural sub-module, lutram_rr_arbiter2: 2-way round-robin, grant plus last_grant register, pure arbitration.
- The top holds the FSM, the clear counter and the response registers.

Test Plan:
- Reset with LUTRAM_ARB_CLEAR_EN defined: init_done=0 for 32 cycles, ram_addr sweeps 0..31 with ram_we=1 and din=0, then init_done=1. Reasserting reset at clear address 10 restarts the sweep at 0.
- Port 0 writes addr 5 = 0xBEEF, next cycle port 0 reads addr 5: rsp0_valid one cycle later, rsp0_data=0xBEEF, rsp1_valid stays 0.
- Both ports hold valid reads (addr 1, addr 2) for 6 cycles from reset: grants 0,1,0,1,0,1; responses alternate, each 1 cycle after its grant.
- Port 1 writes addr 31 = 0x1234 while port 0 reads addr 31 in the same cycle (port 1 wins by pointer): port 0 stalls one cycle, then reads 0x1234.
- Without the macro, after reset: read addr 0 returns the RAM INIT value (0x0000 for default INIT), and init_done=1 on the first cycle after reset.
- Port 0 only, 4 back-to-back reads addr 0..3 preloaded 0xA0..0xA3: rsp0_valid high for 4 consecutive cycles, data 0xA0..0xA3 in order.
